// File: rtl/dt_inference_scheduler.sv
// Scheduler between the CAN feature extractor and decision_tree_engine:
// queues feature sets, launches one engine run per set, watchdogs it and returns tagged results.
module dt_inference_scheduler #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_feat_00,
  input  logic [63:0] in_feat_01,
  input  logic [63:0] in_feat_10,
  input  logic [7:0]  in_tag,
  output logic        eng_start,
  input  logic        eng_busy,
  input  logic        eng_done,
  input  logic [1:0]  eng_result,
  input  logic        eng_is_attack,
  output logic [63:0] eng_feat_00,
  output logic [63:0] eng_feat_01,
  output logic [63:0] eng_feat_10,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_tag,
  output logic [1:0]  out_result,
  output logic        out_is_attack,
  output logic        out_timeout,
  output logic [15:0] frame_count,
  output logic [15:0] attack_count,
  output logic [15:0] timeout_count,
  output logic [2:0]  sched_state
);

  localparam int unsigned FEAT_W  = 64;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned ENTRY_W = 3 * FEAT_W + TAG_W;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WD_W    = 16;
  localparam int unsigned STAT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_RESULT = 3'd3,
    S_DRAIN  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                in_ready_q, in_ready_d;
  logic                eng_start_q, eng_start_d;
  logic [FEAT_W-1:0]   feat_00_q, feat_00_d, feat_01_q, feat_01_d, feat_10_q, feat_10_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                out_valid_q, out_valid_d;
  logic [TAG_W-1:0]    out_tag_q, out_tag_d;
  logic [1:0]          out_result_q, out_result_d;
  logic                out_is_attack_q, out_is_attack_d;
  logic                out_timeout_q, out_timeout_d;
  logic [STAT_W-1:0]   frame_count_q, frame_count_d;
  logic [STAT_W-1:0]   attack_count_q, attack_count_d;
  logic [STAT_W-1:0]   timeout_count_q, timeout_count_d;

  logic [ENTRY_W-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]  head_entry;
  logic                push;
  logic                pop;

  assign head_entry = fifo_mem_q[rd_ptr_q];

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {in_feat_00, in_feat_01, in_feat_10, in_tag};
    end
  end

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    eng_start_d     = 1'b0;
    feat_00_d       = feat_00_q;
    feat_01_d       = feat_01_q;
    feat_10_d       = feat_10_q;
    tag_d           = tag_q;
    wd_d            = wd_q;
    out_valid_d     = out_valid_q;
    out_tag_d       = out_tag_q;
    out_result_d    = out_result_q;
    out_is_attack_d = out_is_attack_q;
    out_timeout_d   = out_timeout_q;
    frame_count_d   = frame_count_q;
    attack_count_d  = attack_count_q;
    timeout_count_d = timeout_count_q;
    push            = in_valid & in_ready_q;
    pop             = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !eng_busy) begin
          pop         = 1'b1;
          feat_00_d   = head_entry[ENTRY_W-1 -: FEAT_W];
          feat_01_d   = head_entry[TAG_W+2*FEAT_W-1 -: FEAT_W];
          feat_10_d   = head_entry[TAG_W+FEAT_W-1 -: FEAT_W];
          tag_d       = head_entry[TAG_W-1:0];
          eng_start_d = 1'b1;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        wd_d = wd_q + WD_W'(1);
        if (eng_done) begin
          out_valid_d     = 1'b1;
          out_tag_d       = tag_q;
          out_result_d    = eng_result;
          out_is_attack_d = eng_is_attack;
          out_timeout_d   = 1'b0;
          state_d         = S_RESULT;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          out_valid_d     = 1'b1;
          out_tag_d       = tag_q;
          out_result_d    = 2'b00;
          out_is_attack_d = 1'b0;
          out_timeout_d   = 1'b1;
          state_d         = S_RESULT;
        end
      end
      S_RESULT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (frame_count_q != '1) frame_count_d = frame_count_q + STAT_W'(1);
          if (out_is_attack_q && (attack_count_q != '1)) attack_count_d = attack_count_q + STAT_W'(1);
          if (out_timeout_q && (timeout_count_q != '1)) timeout_count_d = timeout_count_q + STAT_W'(1);
          state_d = (out_timeout_q && eng_busy) ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        // A hung engine must go idle before the next set is issued.
        if (!eng_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d < CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      in_ready_q      <= 1'b0;
      eng_start_q     <= 1'b0;
      feat_00_q       <= '0;
      feat_01_q       <= '0;
      feat_10_q       <= '0;
      tag_q           <= '0;
      wd_q            <= '0;
      out_valid_q     <= 1'b0;
      out_tag_q       <= '0;
      out_result_q    <= '0;
      out_is_attack_q <= 1'b0;
      out_timeout_q   <= 1'b0;
      frame_count_q   <= '0;
      attack_count_q  <= '0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      in_ready_q      <= in_ready_d;
      eng_start_q     <= eng_start_d;
      feat_00_q       <= feat_00_d;
      feat_01_q       <= feat_01_d;
      feat_10_q       <= feat_10_d;
      tag_q           <= tag_d;
      wd_q            <= wd_d;
      out_valid_q     <= out_valid_d;
      out_tag_q       <= out_tag_d;
      out_result_q    <= out_result_d;
      out_is_attack_q <= out_is_attack_d;
      out_timeout_q   <= out_timeout_d;
      frame_count_q   <= frame_count_d;
      attack_count_q  <= attack_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign eng_start     = eng_start_q;
  assign eng_feat_00   = feat_00_q;
  assign eng_feat_01   = feat_01_q;
  assign eng_feat_10   = feat_10_q;
  assign out_valid     = out_valid_q;
  assign out_tag       = out_tag_q;
  assign out_result    = out_result_q;
  assign out_is_attack = out_is_attack_q;
  assign out_timeout   = out_timeout_q;
  assign frame_count   = frame_count_q;
  assign attack_count  = attack_count_q;
  assign timeout_count = timeout_count_q;
  assign sched_state   = state_q;

endmodule

// File: tb/tb_dt_inference_scheduler.sv
// Directed bench for dt_inference_scheduler with a behavioural decision-tree engine.
module tb_dt_inference_scheduler;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 8;
  localparam int          LIMIT = 200;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [63:0] in_feat_00, in_feat_01, in_feat_10;
  logic [7:0]  in_tag;
  logic        eng_start, eng_busy, eng_done, eng_is_attack;
  logic [1:0]  eng_result;
  logic [63:0] eng_feat_00, eng_feat_01, eng_feat_10;
  logic        out_valid, out_ready, out_is_attack, out_timeout;
  logic [7:0]  out_tag;
  logic [1:0]  out_result;
  logic [15:0] frame_count, attack_count, timeout_count;
  logic [2:0]  sched_state;

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;

  // engine model controls
  logic       busy_m, stall, m_hang, m_release, m_att;
  logic [1:0] m_res;
  int         m_lat, cnt;

  assign eng_busy = busy_m | stall;

  dt_inference_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_feat_00(in_feat_00), .in_feat_01(in_feat_01), .in_feat_10(in_feat_10), .in_tag(in_tag),
    .eng_start(eng_start), .eng_busy(eng_busy), .eng_done(eng_done),
    .eng_result(eng_result), .eng_is_attack(eng_is_attack),
    .eng_feat_00(eng_feat_00), .eng_feat_01(eng_feat_01), .eng_feat_10(eng_feat_10),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_result(out_result),
    .out_is_attack(out_is_attack), .out_timeout(out_timeout),
    .frame_count(frame_count), .attack_count(attack_count), .timeout_count(timeout_count),
    .sched_state(sched_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] f00(input logic [7:0] t);
    return {24'h0, t, 32'h8000_0000};
  endfunction
  function automatic logic [63:0] f01(input logic [7:0] t);
    return {56'h0, t};
  endfunction
  function automatic logic [63:0] f10(input logic [7:0] t);
    return {t, 56'h00_0000_0000_0003};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  // Engine: busy from the start pulse, done pulse after m_lat cycles, or hang until released.
  initial begin
    busy_m = 1'b0; eng_done = 1'b0; eng_result = 2'b00; eng_is_attack = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (!rst_n) begin
        busy_m = 1'b0;
        cnt    = 0;
      end else if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          eng_done = 1'b1; eng_result = m_res; eng_is_attack = m_att; busy_m = 1'b0;
        end
      end else if (busy_m) begin
        if (m_release) busy_m = 1'b0;
      end else if (eng_start === 1'b1) begin
        busy_m = 1'b1;
        if (!m_hang) cnt = m_lat;
      end
    end
  end

  always @(negedge clk) if (eng_start === 1'b1) start_cnt++;

  // All tasks begin and end at a falling edge.
  task automatic push(input logic [7:0] t);
    int n = 0;
    while (in_ready !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) chk("push_wait_expired", 64'(n), 64'(0));
    in_valid = 1'b1; in_tag = t;
    in_feat_00 = f00(t); in_feat_01 = f01(t); in_feat_10 = f10(t);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) chk("out_valid_wait_expired", 64'(n), 64'(0));
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (eng_start !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) chk("eng_start_wait_expired", 64'(n), 64'(0));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int snap;
    logic ok;
    logic [63:0] ref_v;
    rst_n = 1'b0; in_valid = 1'b0; in_tag = '0; out_ready = 1'b0;
    in_feat_00 = '0; in_feat_01 = '0; in_feat_10 = '0;
    stall = 1'b0; m_hang = 1'b0; m_release = 1'b0; m_lat = 6; m_res = 2'b01; m_att = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_state", 64'(sched_state), 64'(0));
    chk("rst_frame_count", 64'(frame_count), 64'(0));
    chk("rst_feat", eng_feat_00, 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 64'(1));

    // 1: single frame, done after 6 cycles, class 01 attack
    snap = start_cnt;
    push(8'h11);
    wait_start(n);
    chk("t1_start_latency", 64'(n), 64'(1));
    chk("t1_feat00", eng_feat_00, f00(8'h11));
    chk("t1_feat10", eng_feat_10, f10(8'h11));
    wait_valid(n);
    chk("t1_result_latency", 64'(n), 64'(7));
    chk("t1_tag", 64'(out_tag), 64'(8'h11));
    chk("t1_result", 64'(out_result), 64'(2'b01));
    chk("t1_attack", 64'(out_is_attack), 64'(1));
    chk("t1_timeout", 64'(out_timeout), 64'(0));
    chk("t1_state_result", 64'(sched_state), 64'(3));
    handshake();
    chk("t1_valid_drop", 64'(out_valid), 64'(0));
    chk("t1_attack_count", 64'(attack_count), 64'(1));
    chk("t1_frame_count", 64'(frame_count), 64'(1));
    chk("t1_start_pulses", 64'(start_cnt - snap), 64'(1));

    // 2: fill FIFO while engine stalled, fifth accepted after first pop, in-order results
    stall = 1'b1; m_lat = 3; m_res = 2'b10; m_att = 1'b0;
    push(8'h21); push(8'h22); push(8'h23); push(8'h24);
    chk("t2_full_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("t2_full_hold", 64'(in_ready), 64'(0));
    stall = 1'b0;
    push(8'h25);
    for (int i = 0; i < 5; i++) begin
      wait_valid(n);
      chk($sformatf("t2_tag%0d", i), 64'(out_tag), 64'(8'h21 + i));
      chk($sformatf("t2_res%0d", i), 64'(out_result), 64'(2'b10));
      handshake();
    end
    chk("t2_frame_count", 64'(frame_count), 64'(6));
    chk("t2_attack_count", 64'(attack_count), 64'(1));

    // 3: hung engine hits the watchdog, then DRAIN until busy drops
    m_hang = 1'b1;
    push(8'h33);
    wait_start(n);
    wait_valid(n);
    // decision made in the 8th RUN cycle, registered result visible on the next
    chk("t3_timeout_latency", 64'(n), 64'(TMO + 1));
    chk("t3_timeout", 64'(out_timeout), 64'(1));
    chk("t3_result", 64'(out_result), 64'(0));
    chk("t3_attack", 64'(out_is_attack), 64'(0));
    chk("t3_tag", 64'(out_tag), 64'(8'h33));
    handshake();
    chk("t3_drain", 64'(sched_state), 64'(4));
    chk("t3_timeout_count", 64'(timeout_count), 64'(1));
    chk("t3_frame_count", 64'(frame_count), 64'(7));
    repeat (5) @(negedge clk);
    chk("t3_drain_hold", 64'(sched_state), 64'(4));
    m_release = 1'b1;
    n = 0;
    while (sched_state !== 3'd0 && n < 10) begin @(negedge clk); n++; end
    chk("t3_drain_exit", 64'(sched_state), 64'(0));
    m_hang = 1'b0; m_release = 1'b0;

    // 4: consumer stalls 10 cycles, outputs stable and no new launch
    m_lat = 3; m_res = 2'b10; m_att = 1'b0;
    push(8'h41); push(8'h42);
    wait_valid(n);
    snap  = start_cnt;
    ref_v = {out_tag, out_result, out_is_attack, out_timeout, eng_feat_00[51:0]};
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b1 ||
          {out_tag, out_result, out_is_attack, out_timeout, eng_feat_00[51:0]} !== ref_v) ok = 1'b0;
    end
    chk("t4_stable", 64'(ok), 64'(1));
    chk("t4_tag", 64'(out_tag), 64'(8'h41));
    chk("t4_no_start", 64'(start_cnt - snap), 64'(0));
    handshake();
    wait_start(n);
    chk("t4_next_feat", eng_feat_00, f00(8'h42));
    wait_valid(n);
    chk("t4_next_tag", 64'(out_tag), 64'(8'h42));
    handshake();
    chk("t4_frame_count", 64'(frame_count), 64'(9));

    // 5: reset during RUN with three sets queued
    m_lat = 20;
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    chk("t5_running", 64'(sched_state), 64'(2));
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_state", 64'(sched_state), 64'(0));
    chk("t5_rst_feat", eng_feat_00, 64'(0));
    chk("t5_rst_counts", 64'({frame_count, attack_count, timeout_count}), 64'(0));
    chk("t5_rst_outs", 64'({out_valid, eng_start, in_ready, out_tag}), 64'(0));
    rst_n = 1'b1;
    snap = start_cnt;
    repeat (8) @(negedge clk);
    chk("t5_no_start", 64'(start_cnt - snap), 64'(0));
    chk("t5_in_ready", 64'(in_ready), 64'(1));
    chk("t5_idle", 64'(sched_state), 64'(0));

    // 6: frame counter saturates
    m_lat = 4; m_res = 2'b11; m_att = 1'b1;
    push(8'h61);
    wait_valid(n);
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    chk("t6_result", 64'(out_result), 64'(2'b11));
    handshake();
    chk("t6_frame_sat", 64'(frame_count), 64'(16'hFFFF));
    chk("t6_attack_count", 64'(attack_count), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
